simt_reconv_stack: RTL and testbench

//  Per-warp SIMT divergence/reconvergence engine: holds each warp's active mask plus a

---
 rtl/simt_reconv_stack.sv | 171 +++++++++++++++++
 tb/tb_simt_reconv_stack.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simt_reconv_stack.sv
// Per-warp SIMT divergence/reconvergence engine.
// Keeps one active mask and one LIFO of {pc, mask} entries per warp. A divergent
// branch pushes the reconvergence entry and the deferred not-taken path, then runs
// the taken lanes; each sync pops the next path. Responses are registered and
// appear one cycle after the accepted branch or sync.
module simt_reconv_stack #(
    parameter int WARP_SIZE   = 32,
    parameter int NUM_WARPS   = 4,
    parameter int STACK_DEPTH = 8,
    parameter int PC_W        = 32,
    parameter int WID_W       = $clog2(NUM_WARPS),
    parameter int DEP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_valid,
    input  logic [WID_W-1:0]     init_warp,
    input  logic [WARP_SIZE-1:0] init_mask,
    input  logic                 br_valid,
    input  logic [WID_W-1:0]     br_warp,
    input  logic [WARP_SIZE-1:0] br_taken,
    input  logic [PC_W-1:0]      br_target_pc,
    input  logic [PC_W-1:0]      br_fall_pc,
    input  logic [PC_W-1:0]      br_reconv_pc,
    input  logic                 sync_valid,
    input  logic [WID_W-1:0]     sync_warp,
    input  logic [PC_W-1:0]      sync_pc,
    input  logic [WID_W-1:0]     rd_warp,
    output logic [WARP_SIZE-1:0] rd_mask,
    output logic [DEP_W-1:0]     rd_depth,
    output logic                 resp_valid,
    output logic [WID_W-1:0]     resp_warp,
    output logic [PC_W-1:0]      resp_pc,
    output logic [WARP_SIZE-1:0] resp_mask,
    output logic                 resp_diverged,
    output logic                 op_conflict,
    output logic                 ovf_err,
    output logic                 unf_err
);

    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [WARP_SIZE-1:0] r_mask     [NUM_WARPS];
    logic [DEP_W-1:0]     r_depth    [NUM_WARPS];
    logic [PC_W-1:0]      r_stk_pc   [NUM_WARPS][STACK_DEPTH];
    logic [WARP_SIZE-1:0] r_stk_mask [NUM_WARPS][STACK_DEPTH];

    logic                 r_resp_valid;
    logic [WID_W-1:0]     r_resp_warp;
    logic [PC_W-1:0]      r_resp_pc;
    logic [WARP_SIZE-1:0] r_resp_mask;
    logic                 r_resp_diverged;
    logic                 r_conflict;
    logic                 r_ovf;
    logic                 r_unf;

    logic                 w_do_init;
    logic                 w_do_br;
    logic                 w_do_sync;
    logic                 w_conflict;
    logic [WARP_SIZE-1:0] w_br_m;
    logic [WARP_SIZE-1:0] w_br_t;
    logic [WARP_SIZE-1:0] w_br_n;
    logic                 w_br_div;
    logic                 w_br_push;
    logic [IDX_W-1:0]     w_br_idx;
    logic [DEP_W-1:0]     w_sy_depth;
    logic                 w_sy_empty;
    logic [IDX_W-1:0]     w_sy_idx;
    logic [PC_W-1:0]      w_sy_pc;
    logic [WARP_SIZE-1:0] w_sy_mask;

    // Op arbitration (init > br > sync) and branch/sync decode from current state
    always_comb begin
        w_do_init  = init_valid;
        w_do_br    = br_valid && !init_valid;
        w_do_sync  = sync_valid && !init_valid && !br_valid;
        w_conflict = (init_valid && (br_valid || sync_valid)) || (br_valid && sync_valid);

        w_br_m     = r_mask[br_warp];
        w_br_t     = w_br_m & br_taken;
        w_br_n     = w_br_m & ~br_taken;
        w_br_div   = (|w_br_t) && (|w_br_n);
        w_br_push  = w_br_div && (r_depth[br_warp] <= DEP_W'(STACK_DEPTH - 2));
        w_br_idx   = r_depth[br_warp][IDX_W-1:0];

        // A full stack has depth == STACK_DEPTH whose low bits are zero; the
        // decrement wraps to the correct top index STACK_DEPTH-1.
        w_sy_depth = r_depth[sync_warp];
        w_sy_empty = (w_sy_depth == '0);
        w_sy_idx   = w_sy_depth[IDX_W-1:0] - IDX_W'(1);
        w_sy_pc    = r_stk_pc[sync_warp][w_sy_idx];
        w_sy_mask  = r_stk_mask[sync_warp][w_sy_idx];
    end

    // Stack storage: no reset needed, entries above depth are never read
    always_ff @(posedge clk) begin
        if (w_do_br && w_br_push) begin
            r_stk_pc[br_warp][w_br_idx]               <= br_reconv_pc;
            r_stk_mask[br_warp][w_br_idx]             <= w_br_m;
            r_stk_pc[br_warp][w_br_idx + IDX_W'(1)]   <= br_fall_pc;
            r_stk_mask[br_warp][w_br_idx + IDX_W'(1)] <= w_br_n;
        end
    end

    // Warp masks, depths, registered response and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                r_mask[i]  <= '0;
                r_depth[i] <= '0;
            end
            r_resp_valid    <= 1'b0;
            r_resp_warp     <= '0;
            r_resp_pc       <= '0;
            r_resp_mask     <= '0;
            r_resp_diverged <= 1'b0;
            r_conflict      <= 1'b0;
            r_ovf           <= 1'b0;
            r_unf           <= 1'b0;
        end else begin
            r_resp_valid <= w_do_br || w_do_sync;
            r_conflict   <= w_conflict;
            if (w_do_init) begin
                r_mask[init_warp]  <= init_mask;
                r_depth[init_warp] <= '0;
            end else if (w_do_br) begin
                r_resp_warp     <= br_warp;
                r_resp_diverged <= w_br_push;
                if (w_br_push) begin
                    r_mask[br_warp]  <= w_br_t;
                    r_depth[br_warp] <= r_depth[br_warp] + DEP_W'(2);
                    r_resp_pc        <= br_target_pc;
                    r_resp_mask      <= w_br_t;
                end else if (w_br_div) begin
                    r_ovf       <= 1'b1;
                    r_resp_pc   <= br_fall_pc;
                    r_resp_mask <= w_br_m;
                end else begin
                    r_resp_pc   <= (|w_br_t) ? br_target_pc : br_fall_pc;
                    r_resp_mask <= w_br_m;
                end
            end else if (w_do_sync) begin
                r_resp_warp     <= sync_warp;
                r_resp_diverged <= 1'b0;
                if (w_sy_empty) begin
                    r_unf       <= 1'b1;
                    r_resp_pc   <= sync_pc;
                    r_resp_mask <= r_mask[sync_warp];
                end else begin
                    r_mask[sync_warp]  <= w_sy_mask;
                    r_depth[sync_warp] <= w_sy_depth - DEP_W'(1);
                    r_resp_pc          <= w_sy_pc;
                    r_resp_mask        <= w_sy_mask;
                end
            end
        end
    end

    assign rd_mask       = r_mask[rd_warp];
    assign rd_depth      = r_depth[rd_warp];
    assign resp_valid    = r_resp_valid;
    assign resp_warp     = r_resp_warp;
    assign resp_pc       = r_resp_pc;
    assign resp_mask     = r_resp_mask;
    assign resp_diverged = r_resp_diverged;
    assign op_conflict   = r_conflict;
    assign ovf_err       = r_ovf;
    assign unf_err       = r_unf;

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Bench for simt_reconv_stack: directed scenarios plus random op mix, every
// response and every warp's rd_* state compared against a queue-based model.
module tb_simt_reconv_stack;

    localparam int NW = 4;
    localparam int SD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_valid = 1'b0;
    logic [1:0]  init_warp = '0;
    logic [31:0] init_mask = '0;
    logic        br_valid = 1'b0;
    logic [1:0]  br_warp = '0;
    logic [31:0] br_taken = '0;
    logic [31:0] br_target_pc = '0;
    logic [31:0] br_fall_pc = '0;
    logic [31:0] br_reconv_pc = '0;
    logic        sync_valid = 1'b0;
    logic [1:0]  sync_warp = '0;
    logic [31:0] sync_pc = '0;
    logic [1:0]  rd_warp = '0;
    logic [31:0] rd_mask;
    logic [3:0]  rd_depth;
    logic        resp_valid;
    logic [1:0]  resp_warp;
    logic [31:0] resp_pc;
    logic [31:0] resp_mask;
    logic        resp_diverged;
    logic        op_conflict;
    logic        ovf_err;
    logic        unf_err;

    simt_reconv_stack #(
        .WARP_SIZE  (32),
        .NUM_WARPS  (NW),
        .STACK_DEPTH(SD),
        .PC_W       (32)
    ) dut (
        .clk(clk), .rst(rst),
        .init_valid(init_valid), .init_warp(init_warp), .init_mask(init_mask),
        .br_valid(br_valid), .br_warp(br_warp), .br_taken(br_taken),
        .br_target_pc(br_target_pc), .br_fall_pc(br_fall_pc), .br_reconv_pc(br_reconv_pc),
        .sync_valid(sync_valid), .sync_warp(sync_warp), .sync_pc(sync_pc),
        .rd_warp(rd_warp), .rd_mask(rd_mask), .rd_depth(rd_depth),
        .resp_valid(resp_valid), .resp_warp(resp_warp), .resp_pc(resp_pc),
        .resp_mask(resp_mask), .resp_diverged(resp_diverged),
        .op_conflict(op_conflict), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    // 20-unit clock period
    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: per-warp mask and a queue of {pc, mask} entries (back = top)
    logic [31:0] m_mask [NW];
    logic [63:0] m_stk  [NW][$];
    logic        m_ovf;
    logic        m_unf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_mask[i] = '0;
            m_stk[i].delete();
        end
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_rd();
        for (int w = 0; w < NW; w++) begin
            rd_warp = 2'(w);
            #1;
            check("rd_mask", 64'(rd_mask), 64'(m_mask[w]));
            check("rd_depth", 64'(rd_depth), 64'(m_stk[w].size()));
        end
    endtask

    task automatic do_op(
        input logic iv, input logic [1:0] iw, input logic [31:0] im,
        input logic bv, input logic [1:0] bw, input logic [31:0] bt,
        input logic [31:0] tpc, input logic [31:0] fpc, input logic [31:0] rpc,
        input logic sv, input logic [1:0] sw, input logic [31:0] spc);
        logic        ev, ediv, econf;
        logic [1:0]  ew;
        logic [31:0] epc, emk, m, t, n;
        logic [63:0] e;
        @(negedge clk);
        init_valid = iv; init_warp = iw; init_mask = im;
        br_valid = bv; br_warp = bw; br_taken = bt;
        br_target_pc = tpc; br_fall_pc = fpc; br_reconv_pc = rpc;
        sync_valid = sv; sync_warp = sw; sync_pc = spc;

        ev = 1'b0; ediv = 1'b0; ew = '0; epc = '0; emk = '0;
        econf = (int'(iv) + int'(bv) + int'(sv)) > 1;
        if (iv) begin
            m_mask[iw] = im;
            m_stk[iw].delete();
        end else if (bv) begin
            ev = 1'b1; ew = bw;
            m = m_mask[bw]; t = m & bt; n = m & ~bt;
            emk = m;
            if (t == 0) epc = fpc;
            else if (n == 0) epc = tpc;
            else if (m_stk[bw].size() + 2 <= SD) begin
                m_stk[bw].push_back({rpc, m});
                m_stk[bw].push_back({fpc, n});
                m_mask[bw] = t;
                epc = tpc; emk = t; ediv = 1'b1;
            end else begin
                m_ovf = 1'b1;
                epc = fpc;
            end
        end else if (sv) begin
            ev = 1'b1; ew = sw;
            if (m_stk[sw].size() == 0) begin
                m_unf = 1'b1;
                epc = spc; emk = m_mask[sw];
            end else begin
                e = m_stk[sw].pop_back();
                epc = e[63:32]; emk = e[31:0];
                m_mask[sw] = emk;
            end
        end

        @(posedge clk);
        #1;
        init_valid = 1'b0; br_valid = 1'b0; sync_valid = 1'b0;
        check("resp_valid", 64'(resp_valid), 64'(ev));
        if (ev) begin
            check("resp_warp", 64'(resp_warp), 64'(ew));
            check("resp_pc", 64'(resp_pc), 64'(epc));
            check("resp_mask", 64'(resp_mask), 64'(emk));
            check("resp_diverged", 64'(resp_diverged), 64'(ediv));
        end
        check("op_conflict", 64'(op_conflict), 64'(econf));
        check("ovf_err", 64'(ovf_err), 64'(m_ovf));
        check("unf_err", 64'(unf_err), 64'(m_unf));
        check_rd();
    endtask

    task automatic br(input logic [1:0] w, input logic [31:0] bt,
                      input logic [31:0] tpc, input logic [31:0] fpc, input logic [31:0] rpc);
        do_op(1'b0, 2'd0, '0, 1'b1, w, bt, tpc, fpc, rpc, 1'b0, 2'd0, '0);
    endtask

    task automatic sync(input logic [1:0] w, input logic [31:0] spc);
        do_op(1'b0, 2'd0, '0, 1'b0, 2'd0, '0, '0, '0, '0, 1'b1, w, spc);
    endtask

    task automatic init(input logic [1:0] w, input logic [31:0] im);
        do_op(1'b1, w, im, 1'b0, 2'd0, '0, '0, '0, '0, 1'b0, 2'd0, '0);
    endtask

    initial begin
        logic [31:0] bt;
        model_reset();
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_pc", 64'(resp_pc), 64'd0);
        check("rst_errs", 64'({ovf_err, unf_err, op_conflict}), 64'd0);
        check_rd();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Divergence and two-step reconvergence on warp 0
        init(2'd0, 32'hFFFF_FFFF);
        br(2'd0, 32'h0000_FFFF, 32'h100, 32'h200, 32'h300);
        check("div_pc", 64'(resp_pc), 64'h100);
        check("div_mask", 64'(resp_mask), 64'h0000_FFFF);
        check("div_depth", 64'(dut.rd_depth), 64'(rd_depth));
        sync(2'd0, 32'h180);
        check("pop1_pc", 64'(resp_pc), 64'h200);
        check("pop1_mask", 64'(resp_mask), 64'hFFFF_0000);
        sync(2'd0, 32'h280);
        check("pop2_pc", 64'(resp_pc), 64'h300);
        check("pop2_mask", 64'(resp_mask), 64'hFFFF_FFFF);

        // Uniform taken branch
        br(2'd0, 32'hFFFF_FFFF, 32'h400, 32'h500, 32'h600);
        check("uni_pc", 64'(resp_pc), 64'h400);

        // Four nested divergences fill the stack, fifth overflows
        br(2'd0, 32'h0000_FFFF, 32'h1000, 32'h1100, 32'h1200);
        br(2'd0, 32'h0000_00FF, 32'h2000, 32'h2100, 32'h2200);
        br(2'd0, 32'h0000_000F, 32'h3000, 32'h3100, 32'h3200);
        br(2'd0, 32'h0000_0003, 32'h4000, 32'h4100, 32'h4200);
        br(2'd0, 32'h0000_0001, 32'h5000, 32'h5100, 32'h5200);
        check("ovf_flag", 64'(ovf_err), 64'd1);
        check("ovf_pc", 64'(resp_pc), 64'h5100);
        check("ovf_mask", 64'(resp_mask), 64'h3);

        // Underflow on never-initialised warp 1
        sync(2'd1, 32'h7777);
        check("unf_flag", 64'(unf_err), 64'd1);
        check("unf_pc", 64'(resp_pc), 64'h7777);

        // init beats br in the same cycle
        do_op(1'b1, 2'd2, 32'hA5A5_A5A5, 1'b1, 2'd3, 32'h1, 32'h9, 32'hA, 32'hB, 1'b0, 2'd0, '0);
        // br beats sync in the same cycle
        init(2'd3, 32'hF0F0_F0F0);
        do_op(1'b0, 2'd0, '0, 1'b1, 2'd3, 32'h00FF_00FF, 32'h11, 32'h22, 32'h33, 1'b1, 2'd3, 32'h44);

        // Random op mix
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0: bt = '0;
                1: bt = '1;
                default: bt = $urandom;
            endcase
            do_op($urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? '1 : $urandom,
                  $urandom_range(0, 1) == 0, 2'($urandom_range(0, 3)), bt, $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom);
        end

        // Asynchronous reset in the middle of a pending branch
        init(2'd1, 32'hFFFF_FFFF);
        br(2'd1, 32'h0F0F_0F0F, 32'h10, 32'h20, 32'h30);
        @(negedge clk);
        rd_warp = 2'd1;
        br_valid = 1'b1; br_warp = 2'd1; br_taken = 32'h0000_0F0F;
        #2;
        rst = 1'b1;
        #1;
        check("arst_rd_mask", 64'(rd_mask), 64'd0);
        check("arst_rd_depth", 64'(rd_depth), 64'd0);
        check("arst_resp", 64'({resp_valid, resp_diverged, op_conflict, ovf_err, unf_err}), 64'd0);
        check("arst_resp_pc", 64'(resp_pc), 64'd0);
        check("arst_resp_mask", 64'(resp_mask), 64'd0);
        @(posedge clk);
        #1;
        check("arst_edge_valid", 64'(resp_valid), 64'd0);
        br_valid = 1'b0;
        model_reset();
        check_rd();
        @(negedge clk);
        rst = 1'b0;
        init(2'd1, 32'h0000_FFFF);
        br(2'd1, 32'h0000_00FF, 32'h50, 32'h60, 32'h70);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
